// File: rtl/instruction_fetch_stage_if.sv
// rtl/instruction_fetch_stage_if.sv - loader, PC-steering and IF/ID output bundle of the fetch stage
interface instruction_fetch_stage_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
);
    logic               en_pipeline;
    logic               start_i;
    logic               load_en_i;
    logic [NB_ADDR-1:0] load_addr_i;
    logic [NB_DATA-1:0] load_data_i;
    logic [1:0]         pc_src_i;
    logic [NB_DATA-1:0] branch_addr_i;
    logic [NB_DATA-1:0] jump_addr_i;
    logic [NB_DATA-1:0] jr_addr_i;
    logic [NB_DATA-1:0] pc_o;
    logic [NB_DATA-1:0] instruction_o;
    logic               halt_o;

    modport master (
        output en_pipeline, start_i, load_en_i, load_addr_i, load_data_i,
        output pc_src_i, branch_addr_i, jump_addr_i, jr_addr_i,
        input  pc_o, instruction_o, halt_o
    );

    modport slave (
        input  en_pipeline, start_i, load_en_i, load_addr_i, load_data_i,
        input  pc_src_i, branch_addr_i, jump_addr_i, jr_addr_i,
        output pc_o, instruction_o, halt_o
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - MIPS IF stage: PC, loadable instruction memory, LOAD/RUN/HALT control
module instruction_fetch_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    instruction_fetch_stage_if.slave    fetch_if
);
    localparam int                 DEPTH     = 1 << NB_ADDR;
    localparam logic [NB_DATA-1:0] HALT_WORD = '1;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] pc_q, pc_d;
    logic [NB_DATA-1:0] pc_plus4;
    logic [NB_DATA-1:0] fetch_word;
    logic [NB_ADDR-1:0] rd_addr;
    logic [NB_DATA-1:0] mem_q [DEPTH];

    assign pc_plus4   = pc_q + NB_DATA'(4);
    // Word-addressed read; PC bits above the memory depth alias, so the address wraps.
    assign rd_addr    = pc_q[NB_ADDR+1:2];
    assign fetch_word = mem_q[rd_addr];

    // Contents survive reset so a program can be re-run without reloading.
    always_ff @(posedge clock_i) begin
        if (state_q == ST_LOAD && fetch_if.load_en_i) begin
            mem_q[fetch_if.load_addr_i] <= fetch_if.load_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_LOAD: begin
                pc_d = '0;
                if (fetch_if.start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fetch_if.en_pipeline) begin
                    case (fetch_if.pc_src_i)
                        2'b00: begin
                            // A redirect never reaches here, so a wrong-path HALT word cannot stop the stage.
                            if (fetch_word == HALT_WORD) begin
                                state_d = ST_HALT;
                            end else begin
                                pc_d = pc_plus4;
                            end
                        end
                        2'b01:   pc_d = fetch_if.branch_addr_i;
                        2'b10:   pc_d = fetch_if.jump_addr_i;
                        default: pc_d = fetch_if.jr_addr_i;
                    endcase
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_LOAD;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign fetch_if.instruction_o = (state_q == ST_RUN) ? fetch_word : '0;
    assign fetch_if.pc_o          = (state_q == ST_LOAD) ? '0 : pc_plus4;
    assign fetch_if.halt_o        = (state_q == ST_HALT);
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - self-checking bench for instruction_fetch_stage
module tb_instruction_fetch_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    instruction_fetch_stage_if #(.NB_DATA(32), .NB_ADDR(8)) ifc ();

    instruction_fetch_stage #(.NB_DATA(32), .NB_ADDR(8)) dut (
        .clock_i  (clk),
        .reset_i  (rst_n),
        .fetch_if (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: 0 = loading, 1 = running, 2 = halted
    logic [31:0] mem_m [256];
    logic [31:0] pc_m;
    int          st_m;

    function automatic logic [31:0] mem_at(logic [31:0] pc);
        return mem_m[int'((pc >> 2) & 32'd255)];
    endfunction

    task automatic model_reset();
        st_m = 0;
        pc_m = 32'd0;
    endtask

    task automatic model_edge();
        if (st_m == 0) begin
            if (ifc.load_en_i) mem_m[int'(ifc.load_addr_i)] = ifc.load_data_i;
            if (ifc.start_i) st_m = 1;
        end else if (st_m == 1 && ifc.en_pipeline) begin
            if (ifc.pc_src_i == 2'd1)      pc_m = ifc.branch_addr_i;
            else if (ifc.pc_src_i == 2'd2) pc_m = ifc.jump_addr_i;
            else if (ifc.pc_src_i == 2'd3) pc_m = ifc.jr_addr_i;
            else if (mem_at(pc_m) == 32'hFFFF_FFFF) st_m = 2;
            else pc_m = pc_m + 32'd4;
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(string tag);
        logic [31:0] exp_pc;
        logic [31:0] exp_ins;
        exp_pc  = (st_m == 0) ? 32'd0 : pc_m + 32'd4;
        exp_ins = (st_m == 1) ? mem_at(pc_m) : 32'd0;
        check({tag, ".pc"},   ifc.pc_o, exp_pc);
        check({tag, ".ins"},  ifc.instruction_o, exp_ins);
        check({tag, ".halt"}, 32'(ifc.halt_o), (st_m == 2) ? 32'd1 : 32'd0);
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic drive_idle();
        ifc.en_pipeline   = 1'b0;
        ifc.start_i       = 1'b0;
        ifc.load_en_i     = 1'b0;
        ifc.load_addr_i   = 8'($urandom);
        ifc.load_data_i   = $urandom;
        ifc.pc_src_i      = 2'd0;
        ifc.branch_addr_i = $urandom;
        ifc.jump_addr_i   = $urandom;
        ifc.jr_addr_i     = $urandom;
    endtask

    task automatic drive_random();
        ifc.en_pipeline   = ($urandom_range(0, 3) != 0);
        ifc.start_i       = 1'($urandom);
        ifc.load_en_i     = 1'($urandom);
        ifc.load_addr_i   = 8'($urandom);
        ifc.load_data_i   = $urandom;
        ifc.pc_src_i      = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        ifc.branch_addr_i = $urandom;
        ifc.jump_addr_i   = $urandom;
        ifc.jr_addr_i     = $urandom;
    endtask

    // Reset pulse placed between edges; outputs must clear with no clock edge.
    task automatic async_reset(string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic redirect(logic [1:0] src, logic [31:0] target);
        drive_idle();
        ifc.en_pipeline = 1'b1;
        ifc.pc_src_i    = src;
        ifc.branch_addr_i = target;
        ifc.jump_addr_i   = target;
        ifc.jr_addr_i     = target;
    endtask

    initial begin
        logic [31:0] word;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        model_reset();
        drive_random();
        @(negedge clk);
        @(negedge clk);
        check("rst.pc", ifc.pc_o, 32'd0);
        check("rst.ins", ifc.instruction_o, 32'd0);
        check("rst.halt", 32'(ifc.halt_o), 32'd0);
        rst_n = 1'b1;

        // Fill the whole memory; the final write shares its cycle with start.
        for (int a = 0; a < 256; a++) begin
            drive_idle();
            if (a == 0)      word = 32'h2001_0005;
            else if (a == 1) word = 32'h2002_0007;
            else if (a == 2) word = 32'hFFFF_FFFF;
            else begin
                word = $urandom;
                if (word == 32'hFFFF_FFFF) word = 32'd0;
            end
            ifc.load_en_i   = 1'b1;
            ifc.load_addr_i = 8'(a);
            ifc.load_data_i = word;
            ifc.start_i     = (a == 255);
            tick("load");
        end
        check("first.pc", ifc.pc_o, 32'd4);
        check("first.ins", ifc.instruction_o, 32'h2001_0005);

        drive_idle();
        ifc.en_pipeline = 1'b1;
        tick("seq1");
        check("seq1.pc", ifc.pc_o, 32'd8);
        check("seq1.ins", ifc.instruction_o, 32'h2002_0007);

        for (int i = 0; i < 3; i++) begin
            drive_idle();
            ifc.pc_src_i = 2'($urandom_range(0, 3));
            tick("stall");
            check("stall.pc", ifc.pc_o, 32'd8);
            check("stall.ins", ifc.instruction_o, 32'h2002_0007);
        end

        drive_idle();
        ifc.en_pipeline = 1'b1;
        tick("seq2");
        check("seq2.pc", ifc.pc_o, 32'd12);
        check("seq2.ins", ifc.instruction_o, 32'hFFFF_FFFF);
        tick("halt");
        check("halt.halt", 32'(ifc.halt_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive_random();
            tick("halted");
            check("halted.pc", ifc.pc_o, 32'd12);
            check("halted.ins", ifc.instruction_o, 32'd0);
        end

        async_reset("arst_halt");
        drive_idle();
        ifc.start_i = 1'b1;
        tick("restart");
        check("retain.pc", ifc.pc_o, 32'd4);
        check("retain.ins", ifc.instruction_o, 32'h2001_0005);

        redirect(2'd1, 32'h40);
        ifc.load_en_i   = 1'b1;
        ifc.load_addr_i = 8'd0;
        ifc.load_data_i = 32'hDEAD_BEEF;
        tick("branch");
        check("branch.pc", ifc.pc_o, 32'h44);
        redirect(2'd2, 32'h80);
        tick("jump");
        check("jump.pc", ifc.pc_o, 32'h84);
        redirect(2'd3, 32'h404);
        tick("jr");
        check("jr.pc", ifc.pc_o, 32'h408);
        check("jr.ins", ifc.instruction_o, 32'h2002_0007);
        redirect(2'd1, 32'h8);
        tick("to_halt_word");
        check("to_halt_word.ins", ifc.instruction_o, 32'hFFFF_FFFF);
        redirect(2'd1, 32'h0);
        tick("beat_halt");
        check("beat_halt.halt", 32'(ifc.halt_o), 32'd0);
        check("beat_halt.pc", ifc.pc_o, 32'd4);
        check("gated_write.ins", ifc.instruction_o, 32'h2001_0005);

        redirect(2'd1, 32'hFFFF_FFFC);
        tick("wrap_top");
        check("wrap_top.pc", ifc.pc_o, 32'd0);
        drive_idle();
        ifc.en_pipeline = 1'b1;
        tick("wrap");
        check("wrap.pc", ifc.pc_o, 32'd4);

        async_reset("arst_run");
        drive_idle();
        ifc.start_i = 1'b1;
        tick("restart2");

        for (int i = 0; i < 600; i++) begin
            if (st_m == 2) begin
                async_reset("arst_rnd");
                drive_idle();
                ifc.start_i = 1'b1;
                tick("restart_rnd");
            end
            drive_random();
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
